alu_cmd_issuer: RTL

- Command front-end that sits directly upstream of the 4-bit combinational ALU (AND/OR/XOR/ADD).
- Buffers operand/opcode commands in a small FIFO and drives the ALU's A, B and op inputs from the FIFO head.
- Captures the ALU result into an output register with a valid/ready handshake.
- Keeps an accumulator of the last result, so a command can use the accumulator as operand A to chain operations.

---
 rtl/alu_cmd_issuer_if.sv | 25 ++
 rtl/alu_cmd_issuer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer_if.sv
// Command/result bus between an upstream producer, the ALU command issuer and a result consumer.
// valid/ready: a transfer happens on a rising clk edge where valid && ready; the sender holds its payload until then.
interface alu_cmd_issuer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Command FIFO feeding a combinational 4-op ALU, with a registered result stage and a
// chaining accumulator that a command may substitute for operand A.
module alu_cmd_issuer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    alu_cmd_issuer_if.slave  bus,
    input  logic             clr_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_ans,
    output logic [WIDTH-1:0] acc,
    output logic [CW-1:0]    count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       op;
        logic             use_acc;
    } cmd_t;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    cmd_t             mem_q [DEPTH];
    cmd_t             mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    state_t           state_q, state_d;

    cmd_t head;
    logic empty;
    logic push;
    logic pop;

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    // No full-bypass: a pop in the same cycle does not reopen a full FIFO.
    assign bus.in_ready = (count_q != FULL);
    assign push  = bus.in_valid && bus.in_ready;
    assign pop   = !empty && (!out_valid_q || bus.out_ready);

    assign alu_a  = empty ? '0 : (head.use_acc ? acc_q : head.a);
    assign alu_b  = empty ? '0 : head.b;
    assign alu_op = empty ? 2'b00 : head.op;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign acc           = acc_q;
    assign count         = count_q;
    assign dbg_state     = state_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{a: bus.in_a, b: bus.in_b, op: bus.in_op, use_acc: bus.in_acc};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        acc_d       = acc_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = alu_ans;
            acc_d       = alu_ans;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        // The head already computed with the old acc; the clear only affects later commands.
        if (clr_acc) begin
            acc_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pop) state_d = BUSY;
            end
            BUSY: begin
                if (out_valid_q && !bus.out_ready && !empty) state_d = BLOCKED;
                else if (!out_valid_d && count_d == '0)       state_d = IDLE;
            end
            BLOCKED: begin
                if (bus.out_ready) state_d = BUSY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
            state_q     <= IDLE;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            acc_q       <= acc_d;
            state_q     <= state_d;
        end
    end

endmodule
